diag_mode_ctrl: RTL and testbench

Parametrised diagnostic-mode controller for the constellation display path, in the clk_dsp domain between the TX/channel/RX taps and constellation_renderer. It debounces NUM_BTN active-low push buttons and classifies each press as short or long. Button 0 steps the mode up, button 1 steps it down, and a long press on button 0 jumps to the full-RX mode. It muxes NUM_SRC I/Q sample streams to one registered display stream, with per-source symbol-rate gating and a post-switch blanking window so the renderer never plots mixed-source points.

---
 rtl/diag_mode_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_diag_mode_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/diag_mode_ctrl.sv
// Diagnostic-mode controller: debounced buttons with short/long press classification
// select one of NUM_SRC I/Q streams, with symbol-rate gating and post-switch blanking.
module diag_mode_ctrl #(
    parameter int                 NUM_SRC    = 4,
    parameter int                 DATA_W     = 12,
    parameter int                 NUM_BTN    = 2,
    parameter int                 DEBOUNCE_W = 19,
    parameter int                 LONG_CYC   = 27_000_000,
    parameter int                 BLANK_CYC  = 4096,
    parameter logic [NUM_SRC-1:0] GATE_MASK  = 4'b0110
) (
    input  logic                        clk_dsp,
    input  logic                        sys_rst_n,
    input  logic [NUM_BTN-1:0]          btn_n,
    input  logic [NUM_SRC*DATA_W-1:0]   src_I,
    input  logic [NUM_SRC*DATA_W-1:0]   src_Q,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC-1:0]          src_strobe,
    output logic [DATA_W-1:0]           disp_I,
    output logic [DATA_W-1:0]           disp_Q,
    output logic                        disp_valid,
    output logic [$clog2(NUM_SRC)-1:0]  mode,
    output logic                        mode_change,
    output logic [NUM_BTN-1:0]          btn_level,
    output logic [NUM_BTN-1:0]          long_press
);

    localparam int MODE_W  = $clog2(NUM_SRC);
    localparam int HOLD_W  = $clog2(LONG_CYC + 1);
    localparam int BLANK_W = $clog2(BLANK_CYC + 1);

    localparam logic [MODE_W-1:0]     MODE_MAX   = MODE_W'(NUM_SRC - 1);
    localparam logic [HOLD_W-1:0]     HOLD_HIT   = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0]     HOLD_SAT   = HOLD_W'(LONG_CYC);
    localparam logic [BLANK_W-1:0]    BLANK_LOAD = BLANK_W'(BLANK_CYC);
    localparam logic [DEBOUNCE_W-1:0] DB_FULL    = {DEBOUNCE_W{1'b1}};

    logic [NUM_BTN-1:0]    sync1_r;
    logic [NUM_BTN-1:0]    sync2_r;
    logic [NUM_BTN-1:0]    stable_r;
    logic [NUM_BTN-1:0]    stable_d_r;
    logic [NUM_BTN-1:0]    long_flag_r;
    logic [NUM_BTN-1:0]    long_press_r;
    logic [DEBOUNCE_W-1:0] db_cnt_r   [NUM_BTN];
    logic [HOLD_W-1:0]     hold_cnt_r [NUM_BTN];

    logic [NUM_BTN-1:0]    flip_s;
    logic [NUM_BTN-1:0]    press_edge_s;
    logic [NUM_BTN-1:0]    release_s;
    logic [NUM_BTN-1:0]    long_hit_s;
    logic [NUM_BTN-1:0]    short_s;

    logic [MODE_W-1:0]     mode_r;
    logic [MODE_W-1:0]     mode_nxt_s;
    logic                  mode_upd_s;
    logic                  mode_change_r;
    logic [BLANK_W-1:0]    blank_cnt_r;

    logic [DATA_W-1:0]     sel_i_s;
    logic [DATA_W-1:0]     sel_q_s;
    logic                  sel_valid_s;
    logic [DATA_W-1:0]     disp_i_r;
    logic [DATA_W-1:0]     disp_q_r;
    logic                  disp_valid_r;

    // Per-button event decode from the debounce and hold state
    always_comb begin
        flip_s       = {NUM_BTN{1'b0}};
        press_edge_s = {NUM_BTN{1'b0}};
        release_s    = {NUM_BTN{1'b0}};
        long_hit_s   = {NUM_BTN{1'b0}};
        for (int b = 0; b < NUM_BTN; b++) begin
            flip_s[b]       = (sync2_r[b] != stable_r[b]) && (db_cnt_r[b] == DB_FULL);
            press_edge_s[b] = flip_s[b] & ~sync2_r[b];
            release_s[b]    = stable_r[b] & ~stable_d_r[b];
            long_hit_s[b]   = ~stable_r[b] & (hold_cnt_r[b] == HOLD_HIT);
        end
        short_s = release_s & ~long_flag_r;
    end

    // Synchroniser and debounce; the counter is cleared when stable flips so a
    // bounce right after a flip must again last the full window
    always_ff @(posedge clk_dsp or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_r    <= {NUM_BTN{1'b1}};
            sync2_r    <= {NUM_BTN{1'b1}};
            stable_r   <= {NUM_BTN{1'b1}};
            stable_d_r <= {NUM_BTN{1'b1}};
            for (int b = 0; b < NUM_BTN; b++) begin
                db_cnt_r[b] <= {DEBOUNCE_W{1'b0}};
            end
        end else begin
            sync1_r    <= btn_n;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            for (int b = 0; b < NUM_BTN; b++) begin
                if (sync2_r[b] == stable_r[b]) begin
                    db_cnt_r[b] <= {DEBOUNCE_W{1'b0}};
                end else if (flip_s[b]) begin
                    stable_r[b] <= sync2_r[b];
                    db_cnt_r[b] <= {DEBOUNCE_W{1'b0}};
                end else begin
                    db_cnt_r[b] <= db_cnt_r[b] + DEBOUNCE_W'(1);
                end
            end
        end
    end

    // Hold counter, long-press pulse and long flag per button
    always_ff @(posedge clk_dsp or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            long_flag_r  <= {NUM_BTN{1'b0}};
            long_press_r <= {NUM_BTN{1'b0}};
            for (int b = 0; b < NUM_BTN; b++) begin
                hold_cnt_r[b] <= {HOLD_W{1'b0}};
            end
        end else begin
            long_press_r <= long_hit_s;
            for (int b = 0; b < NUM_BTN; b++) begin
                if (press_edge_s[b]) begin
                    hold_cnt_r[b] <= {HOLD_W{1'b0}};
                end else if (!stable_r[b] && (hold_cnt_r[b] != HOLD_SAT)) begin
                    hold_cnt_r[b] <= hold_cnt_r[b] + HOLD_W'(1);
                end else begin
                    hold_cnt_r[b] <= hold_cnt_r[b];
                end
                if (release_s[b]) begin
                    long_flag_r[b] <= 1'b0;
                end else if (long_hit_s[b]) begin
                    long_flag_r[b] <= 1'b1;
                end else begin
                    long_flag_r[b] <= long_flag_r[b];
                end
            end
        end
    end

    // Mode next-state: long jump beats up-step beats down-step
    always_comb begin
        mode_nxt_s = mode_r;
        mode_upd_s = 1'b0;
        if (long_hit_s[0]) begin
            mode_nxt_s = MODE_MAX;
            mode_upd_s = 1'b1;
        end else if (short_s[0]) begin
            mode_nxt_s = (mode_r == MODE_MAX) ? {MODE_W{1'b0}} : mode_r + MODE_W'(1);
            mode_upd_s = 1'b1;
        end else if (short_s[1]) begin
            mode_nxt_s = (mode_r == {MODE_W{1'b0}}) ? MODE_MAX : mode_r - MODE_W'(1);
            mode_upd_s = 1'b1;
        end else begin
            mode_nxt_s = mode_r;
            mode_upd_s = 1'b0;
        end
    end

    // Mode register, change pulse and blanking counter
    always_ff @(posedge clk_dsp or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_r        <= {MODE_W{1'b0}};
            mode_change_r <= 1'b0;
            blank_cnt_r   <= {BLANK_W{1'b0}};
        end else begin
            mode_r        <= mode_nxt_s;
            mode_change_r <= mode_upd_s;
            if (mode_upd_s) begin
                blank_cnt_r <= BLANK_LOAD;
            end else if (blank_cnt_r != {BLANK_W{1'b0}}) begin
                blank_cnt_r <= blank_cnt_r - BLANK_W'(1);
            end else begin
                blank_cnt_r <= blank_cnt_r;
            end
        end
    end

    // Source mux driven by the mode value before any same-cycle update
    always_comb begin
        sel_i_s     = {DATA_W{1'b0}};
        sel_q_s     = {DATA_W{1'b0}};
        sel_valid_s = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (mode_r == MODE_W'(s)) begin
                sel_i_s     = src_I[s*DATA_W +: DATA_W];
                sel_q_s     = src_Q[s*DATA_W +: DATA_W];
                sel_valid_s = src_valid[s] & (~GATE_MASK[s] | src_strobe[s]);
            end else begin
                sel_i_s     = sel_i_s;
                sel_q_s     = sel_q_s;
                sel_valid_s = sel_valid_s;
            end
        end
    end

    // Registered display stream
    always_ff @(posedge clk_dsp or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            disp_i_r     <= {DATA_W{1'b0}};
            disp_q_r     <= {DATA_W{1'b0}};
            disp_valid_r <= 1'b0;
        end else begin
            disp_i_r     <= sel_i_s;
            disp_q_r     <= sel_q_s;
            disp_valid_r <= sel_valid_s & (blank_cnt_r == {BLANK_W{1'b0}});
        end
    end

    assign disp_I      = disp_i_r;
    assign disp_Q      = disp_q_r;
    assign disp_valid  = disp_valid_r;
    assign mode        = mode_r;
    assign mode_change = mode_change_r;
    assign btn_level   = ~stable_r;
    assign long_press  = long_press_r;

endmodule

// File: tb/tb_diag_mode_ctrl.sv
// Directed bench for diag_mode_ctrl with a scoreboard on the display stream.
module tb_diag_mode_ctrl;

    localparam int         NS = 4;
    localparam int         DW = 12;
    localparam logic [3:0] GM = 4'b0110;

    logic             clk_dsp = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic [1:0]       btn_n = 2'b11;
    logic [NS*DW-1:0] src_I = '0;
    logic [NS*DW-1:0] src_Q = '0;
    logic [NS-1:0]    src_valid = '0;
    logic [NS-1:0]    src_strobe = '0;
    logic [DW-1:0]    disp_I;
    logic [DW-1:0]    disp_Q;
    logic             disp_valid;
    logic [1:0]       mode;
    logic             mode_change;
    logic [1:0]       btn_level;
    logic [1:0]       long_press;

    int vectors = 0;
    int miscompares = 0;
    int mc_cnt = 0;
    int lp_cnt = 0;
    logic lvl_seen = 1'b0;

    typedef struct packed {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        logic          v;
    } exp_t;
    exp_t sb_q[$];

    diag_mode_ctrl #(
        .NUM_SRC(NS), .DATA_W(DW), .NUM_BTN(2), .DEBOUNCE_W(4),
        .LONG_CYC(100), .BLANK_CYC(8), .GATE_MASK(GM)
    ) dut (
        .clk_dsp(clk_dsp), .sys_rst_n(sys_rst_n), .btn_n(btn_n),
        .src_I(src_I), .src_Q(src_Q), .src_valid(src_valid), .src_strobe(src_strobe),
        .disp_I(disp_I), .disp_Q(disp_Q), .disp_valid(disp_valid),
        .mode(mode), .mode_change(mode_change),
        .btn_level(btn_level), .long_press(long_press)
    );

    always #5 clk_dsp = ~clk_dsp;

    // Pulse counters sampled mid-cycle
    always @(negedge clk_dsp) begin
        if (mode_change === 1'b1) mc_cnt++;
        if (long_press[0] === 1'b1) lp_cnt++;
        if (btn_level[0] === 1'b1) lvl_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk_dsp);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Press the buttons in 'which' for 40 cycles; returns right after the mode-update edge when tail is 0
    task automatic short_press(input logic [1:0] which, input logic [1:0] exp_mode,
                               input string tag, input bit tail);
        int mc0;
        btn_n = ~which;
        repeat (17) tick();
        chk({tag, "_lvl_pre"}, 32'(btn_level), 32'd0);
        tick();
        chk({tag, "_lvl_rise"}, 32'(btn_level), 32'(which));
        repeat (22) tick();
        btn_n = 2'b11;
        mc0 = mc_cnt;
        repeat (18) tick();
        chk({tag, "_lvl_fall"}, 32'(btn_level), 32'd0);
        chk({tag, "_mc_early"}, 32'(mode_change), 32'd0);
        tick();
        chk({tag, "_mode"}, 32'(mode), 32'(exp_mode));
        chk({tag, "_mc"}, 32'(mode_change), 32'd1);
        if (tail) begin
            tick();
            chk({tag, "_mc_end"}, 32'(mode_change), 32'd0);
            chk({tag, "_mc_cnt"}, 32'(mc_cnt - mc0), 32'd1);
            repeat (4) tick();
        end
    endtask

    // Drive random samples; expected output is pushed with the stimulus and popped after the edge
    task automatic run_stream(input int src, input int ncyc, input int blank_left, input string tag);
        exp_t e;
        exp_t got;
        for (int i = 0; i < ncyc; i++) begin
            for (int s = 0; s < NS; s++) begin
                src_I[s*DW +: DW] = DW'($urandom);
                src_Q[s*DW +: DW] = DW'($urandom);
            end
            src_valid  = (i % 7 == 3) ? 4'b1111 & ~(4'b0001 << src) : 4'b1111;
            src_strobe = (4'($urandom) & 4'b1101) | ((i % 4 == 0) ? 4'b0010 : 4'b0000);
            e.i = src_I[src*DW +: DW];
            e.q = src_Q[src*DW +: DW];
            e.v = (i >= blank_left) && src_valid[src] && (!GM[src] || src_strobe[src]);
            sb_q.push_back(e);
            tick();
            got = sb_q.pop_front();
            chk({tag, "_I"}, 32'(disp_I), 32'(got.i));
            chk({tag, "_Q"}, 32'(disp_Q), 32'(got.q));
            chk({tag, "_valid"}, 32'(disp_valid), 32'(got.v));
        end
    endtask

    initial begin
        int mc0;
        repeat (3) @(posedge clk_dsp);
        #1;
        sys_rst_n = 1'b1;

        // Reset and idle
        repeat (50) tick();
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_valid", 32'(disp_valid), 32'd0);
        chk("rst_disp_I", 32'(disp_I), 32'd0);
        chk("rst_lvl", 32'(btn_level), 32'd0);
        chk("rst_mc_cnt", 32'(mc_cnt), 32'd0);
        chk("rst_lp", 32'(long_press), 32'd0);

        // Glitch shorter than the debounce window
        btn_n = 2'b10;
        repeat (10) tick();
        btn_n = 2'b11;
        repeat (30) tick();
        chk("glitch_lvl", 32'(lvl_seen), 32'd0);
        chk("glitch_mode", 32'(mode), 32'd0);

        // Four up-steps with wrap, then a down-step with wrap
        short_press(2'b01, 2'd1, "up1", 1'b1);
        short_press(2'b01, 2'd2, "up2", 1'b1);
        short_press(2'b01, 2'd3, "up3", 1'b1);
        short_press(2'b01, 2'd0, "up_wrap", 1'b1);
        chk("up_total_mc", 32'(mc_cnt), 32'd4);
        short_press(2'b10, 2'd3, "dn_wrap", 1'b1);
        short_press(2'b01, 2'd0, "to0", 1'b1);
        short_press(2'b01, 2'd1, "to1", 1'b1);

        // Long press from mode 1
        btn_n = 2'b10;
        repeat (18) tick();
        chk("long_lvl", 32'(btn_level), 32'd1);
        repeat (99) tick();
        chk("long_early", 32'(long_press), 32'd0);
        chk("long_mode_pre", 32'(mode), 32'd1);
        tick();
        chk("long_pulse", 32'(long_press), 32'd1);
        chk("long_mode", 32'(mode), 32'd3);
        chk("long_mc", 32'(mode_change), 32'd1);
        tick();
        chk("long_pulse_end", 32'(long_press), 32'd0);
        repeat (31) tick();
        btn_n = 2'b11;
        mc0 = mc_cnt;
        repeat (25) tick();
        chk("long_rel_mode", 32'(mode), 32'd3);
        chk("long_rel_mc", 32'(mc_cnt - mc0), 32'd0);
        chk("long_lp_cnt", 32'(lp_cnt), 32'd1);

        // Gated source 1 with blanking
        short_press(2'b01, 2'd0, "dp_to0", 1'b1);
        short_press(2'b01, 2'd1, "dp_to1", 1'b0);
        run_stream(1, 40, 8, "src1");

        // Simultaneous short releases at mode 2
        repeat (6) tick();
        short_press(2'b01, 2'd2, "to2", 1'b1);
        short_press(2'b11, 2'd3, "simul", 1'b1);

        // Second mode change three cycles into blanking
        btn_n = 2'b00;
        repeat (18) tick();
        chk("rb_lvl", 32'(btn_level), 32'd3);
        repeat (22) tick();
        btn_n = 2'b01;
        repeat (3) tick();
        btn_n = 2'b11;
        repeat (16) tick();
        chk("rb_mode1", 32'(mode), 32'd0);
        chk("rb_mc1", 32'(mode_change), 32'd1);
        repeat (3) tick();
        chk("rb_mode2", 32'(mode), 32'd3);
        chk("rb_mc2", 32'(mode_change), 32'd1);
        run_stream(3, 14, 8, "src3");

        chk("total_mc", 32'(mc_cnt), 32'd14);
        chk("total_lp", 32'(lp_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
